// File: rtl/bus_arbiter.sv
// Two-master memory bus arbiter.
// A CPU data port (m0) and a DMA device port (m1) share a single memory.
// Each transaction runs IDLE -> ACCESS -> DONE. The winner's address, write
// data and direction are latched when the transaction starts. ACCESS lasts
// WAIT_STATES+1 cycles, and DONE carries a one-cycle ack to the winner.
// When both masters request at once they are served round-robin.
module bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic        cpu_stall,
  output logic [1:0]  grant,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Counter value seen in the final ACCESS cycle.
  localparam logic [3:0] LAST_COUNT = 4'(WAIT_STATES);

  logic [1:0] state;
  logic [3:0] waitCount;
  logic       lastGrant;
  logic       weLatched;
  logic       pickM1;
  logic       lastAccess;

  // Decide which master wins in IDLE. lastGrant=1 means m1 was served last.
  always_comb begin
    pickM1 = m1_req && (!m0_req || !lastGrant);
  end

  // Track the sequencing state, the latched transaction and the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCount <= 4'd0;
      grant     <= 2'b00;
      lastGrant <= 1'b1;
      weLatched <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state     <= ACCESS;
            waitCount <= 4'd0;
            grant     <= pickM1 ? 2'b10 : 2'b01;
            lastGrant <= pickM1;
            weLatched <= pickM1 ? m1_we : m0_we;
            mem_addr  <= pickM1 ? m1_addr : m0_addr;
            mem_wdata <= pickM1 ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          if (lastAccess) begin
            state <= DONE;
            if (!weLatched) begin
              rdata <= mem_rdata;
            end
          end else begin
            waitCount <= waitCount + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Decode memory strobes, acks and the CPU stall from the current state.
  always_comb begin
    lastAccess = (state == ACCESS) && (waitCount == LAST_COUNT);
    mem_en     = (state == ACCESS);
    mem_we     = lastAccess && weLatched;
    m0_ack     = (state == DONE) && grant[0];
    m1_ack     = (state == DONE) && grant[1];
    cpu_stall  = m0_req && !m0_ack;
  end

endmodule
